b_bus_mux_pipe: RTL and testbench

- Parametrised, pipelined successor to the processor's B-bus source multiplexer.
- Selects one of NUM_SRC register outputs or the immediate. The select code comes from the instruction register field or from the control-unit field, chosen by mode.
- Delivers the selected word through a 2-entry valid/ready skid buffer to the ALU B input.
- Adds deterministic handling of illegal codes (zero data plus a sticky error and an error counter) and backpressure.

---
 rtl/b_bus_pkg.sv | 21 ++
 rtl/bus_skid_buf.sv | 73 +++++++
 rtl/b_bus_mux_pipe.sv | 126 ++++++++++++
 tb/tb_b_bus_mux_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/b_bus_pkg.sv
// Shared encodings and helpers for the pipelined B-bus source multiplexer.
package b_bus_pkg;

    typedef enum logic [1:0] {
        MODE_NOP   = 2'd0,
        MODE_SEL_A = 2'd1,
        MODE_SEL_B = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    localparam int unsigned TOTR_CODE = 15;
    localparam int unsigned IMM_CODE  = 23;

    // A code is legal when it names a register source (1..num_src) or the immediate.
    function automatic logic code_is_legal(input int unsigned code,
                                           input int unsigned num_src,
                                           input int unsigned imm_code = IMM_CODE);
        return ((code >= 1) && (code <= num_src)) || (code == imm_code);
    endfunction

endpackage

// File: rtl/bus_skid_buf.sv
// Two-entry valid/ready FIFO with registered head, valid and ready outputs.
module bus_skid_buf #(
    parameter int unsigned PAY_W = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PAY_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PAY_W-1:0] out_data
);

    logic [PAY_W-1:0] ent0_q, ent0_d;
    logic [PAY_W-1:0] ent1_q, ent1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             push_c, pop_c;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        cnt_d   = cnt_q;
        push_c  = in_valid && ready_q;
        pop_c   = valid_q && out_ready;

        if (push_c && pop_c) begin
            // Only reachable with one entry: the new word replaces the head.
            ent0_d = in_data;
        end else if (push_c) begin
            if (cnt_q == 2'd0) begin
                ent0_d = in_data;
                cnt_d  = 2'd1;
            end else begin
                ent1_d = in_data;
                cnt_d  = 2'd2;
            end
        end else if (pop_c) begin
            if (cnt_q == 2'd2) begin
                ent0_d = ent1_q;
                cnt_d  = 2'd1;
            end else begin
                cnt_d  = 2'd0;
            end
        end

        valid_d = (cnt_d != 2'd0);
        ready_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = ent0_q;

endmodule

// File: rtl/b_bus_mux_pipe.sv
// B-bus source multiplexer: decodes the select code at accept, buffers the word
// for the ALU B input, and tracks illegal selects.
module b_bus_mux_pipe
    import b_bus_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_SRC   = TOTR_CODE,
    parameter int unsigned SEL_W     = 5,
    parameter int unsigned IMM_CODE  = b_bus_pkg::IMM_CODE,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [DATA_W-1:0]         imm_data,
    input  logic [SEL_W-1:0]          sel_a,
    input  logic [SEL_W-1:0]          sel_b,
    input  logic [1:0]                mode,
    input  logic                      req_valid,
    output logic                      req_ready,
    output logic [DATA_W-1:0]         bus_out,
    output logic [SEL_W-1:0]          bus_src,
    output logic                      bus_valid,
    input  logic                      bus_ready,
    output logic                      err_sel,
    output logic [ERR_CNT_W-1:0]      err_count,
    input  logic                      err_clr
);

    localparam int unsigned PAY_W = DATA_W + SEL_W;

    logic [SEL_W-1:0]     code_c;
    logic                 active_c;
    logic                 legal_c;
    logic [DATA_W-1:0]    data_c;
    logic [SEL_W-1:0]     src_c;
    logic                 accept_c;
    logic                 push_c;
    logic                 err_event_c;

    logic                 err_sel_q, err_sel_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    // Resolve the select code and source word; illegal codes drive zero.
    always_comb begin
        code_c   = '0;
        active_c = 1'b0;
        legal_c  = 1'b0;
        data_c   = '0;
        src_c    = '0;

        case (mode_e'(mode))
            MODE_SEL_A: begin
                code_c   = sel_a;
                active_c = 1'b1;
                legal_c  = code_is_legal(32'(sel_a), NUM_SRC, IMM_CODE);
            end
            MODE_SEL_B: begin
                code_c   = sel_b;
                active_c = 1'b1;
                legal_c  = code_is_legal(32'(sel_b), NUM_SRC, IMM_CODE);
            end
            MODE_RSVD: active_c = 1'b1;
            default:   active_c = 1'b0;
        endcase

        if (legal_c) begin
            src_c = code_c;
            if (code_c == SEL_W'(IMM_CODE)) begin
                data_c = imm_data;
            end else begin
                for (int k = 1; k <= int'(NUM_SRC); k++) begin
                    if (code_c == SEL_W'(k)) begin
                        data_c = src_data[(k-1)*int'(DATA_W) +: DATA_W];
                    end
                end
            end
        end

        accept_c    = req_valid && req_ready;
        push_c      = accept_c && active_c;
        err_event_c = push_c && !legal_c;
    end

    // Sticky flag and saturating counter; an error in the clear cycle wins.
    always_comb begin
        err_sel_d   = err_sel_q;
        err_count_d = err_count_q;
        if (err_clr) begin
            err_sel_d   = err_event_c;
            err_count_d = err_event_c ? ERR_CNT_W'(1) : '0;
        end else if (err_event_c) begin
            err_sel_d = 1'b1;
            if (!(&err_count_q)) begin
                err_count_d = err_count_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_sel_q   <= err_sel_d;
            err_count_q <= err_count_d;
        end
    end

    bus_skid_buf #(
        .PAY_W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push_c),
        .in_ready  (req_ready),
        .in_data   ({src_c, data_c}),
        .out_valid (bus_valid),
        .out_ready (bus_ready),
        .out_data  ({bus_src, bus_out})
    );

    assign err_sel   = err_sel_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_b_bus_mux_pipe.sv
// Directed self-checking bench for b_bus_mux_pipe.
module tb_b_bus_mux_pipe;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned NUM_SRC   = 15;
    localparam int unsigned SEL_W     = 5;
    localparam int unsigned ERR_CNT_W = 8;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [DATA_W-1:0]         imm_data;
    logic [SEL_W-1:0]          sel_a;
    logic [SEL_W-1:0]          sel_b;
    logic [1:0]                mode;
    logic                      req_valid;
    logic                      req_ready;
    logic [DATA_W-1:0]         bus_out;
    logic [SEL_W-1:0]          bus_src;
    logic                      bus_valid;
    logic                      bus_ready;
    logic                      err_sel;
    logic [ERR_CNT_W-1:0]      err_count;
    logic                      err_clr;

    int checks = 0;
    int errors = 0;

    b_bus_mux_pipe #(
        .DATA_W    (DATA_W),
        .NUM_SRC   (NUM_SRC),
        .SEL_W     (SEL_W),
        .IMM_CODE  (23),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_data  (src_data),
        .imm_data  (imm_data),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .mode      (mode),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .bus_out   (bus_out),
        .bus_src   (bus_src),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .err_sel   (err_sel),
        .err_count (err_count),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int k, input logic [DATA_W-1:0] val);
        src_data[(k-1)*DATA_W +: DATA_W] = val;
    endtask

    task automatic check_out(input string name, input logic v,
                             input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] s);
        checks++;
        if (bus_valid !== v || (v && (bus_out !== d || bus_src !== s))) begin
            errors++;
            $display("FAIL %s: valid=%0b out=%h src=%0d, expected valid=%0b out=%h src=%0d",
                     name, bus_valid, bus_out, bus_src, v, d, s);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; mode = 2'd0; sel_a = '0; sel_b = '0;
        imm_data = '0; src_data = '0; bus_ready = 1'b0; err_clr = 1'b0;
        for (int k = 1; k <= int'(NUM_SRC); k++) set_src(k, DATA_W'(16'h1000 + k));
        #12;
        checks++;
        if (bus_valid !== 1'b0 || bus_out !== '0 || bus_src !== '0 ||
            err_sel !== 1'b0 || err_count !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b out=%h src=%0d err=%0b cnt=%0d, expected all 0",
                     bus_valid, bus_out, bus_src, err_sel, err_count);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1 || bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%0b valid=%0b, expected 1 0", req_ready, bus_valid);
        end
    endtask

    task automatic test_reg_select();
        bus_ready = 1'b1;
        set_src(3, 16'hA5A5);
        mode = 2'd1; sel_a = 5'd3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check_out("reg_r3", 1'b1, 16'hA5A5, 5'd3);
        tick();
        check_out("reg_r3_drained", 1'b0, '0, '0);
    endtask

    task automatic test_imm_select();
        imm_data = 16'h1234;
        mode = 2'd2; sel_b = 5'd23; sel_a = 5'd5; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        imm_data = 16'hFFFF;
        check_out("imm_sel_b", 1'b1, 16'h1234, 5'd23);
        tick();
        check_out("imm_drained", 1'b0, '0, '0);
    endtask

    task automatic test_back_to_back();
        set_src(1, 16'h0001); set_src(2, 16'h0002); set_src(4, 16'h0004);
        bus_ready = 1'b0; mode = 2'd1; req_valid = 1'b1;
        sel_a = 5'd1; tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_after_1: got %0b expected 1", req_ready);
        end
        sel_a = 5'd2; tick();
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_after_2: got %0b expected 0", req_ready);
        end
        sel_a = 5'd4; tick();
        check_out("bp_hold_head", 1'b1, 16'h0001, 5'd1);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_third_waits: ready=%0b expected 0", req_ready);
        end
        bus_ready = 1'b1; tick();
        check_out("bp_second", 1'b1, 16'h0002, 5'd2);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_after_pop: got %0b expected 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        check_out("bp_third", 1'b1, 16'h0004, 5'd4);
        tick();
        check_out("bp_empty", 1'b0, '0, '0);
    endtask

    task automatic test_errors();
        bus_ready = 1'b1;
        mode = 2'd0; sel_a = 5'd3; req_valid = 1'b1; tick();
        check_out("nop_no_push", 1'b0, '0, '0);
        checks++;
        if (err_sel !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL nop_no_error: err=%0b cnt=%0d expected 0 0", err_sel, err_count);
        end
        mode = 2'd1; sel_a = 5'd20; tick();
        check_out("illegal_20", 1'b1, 16'h0000, 5'd0);
        mode = 2'd3; sel_a = 5'd3; tick();
        req_valid = 1'b0;
        check_out("illegal_rsvd", 1'b1, 16'h0000, 5'd0);
        checks++;
        if (err_sel !== 1'b1 || err_count !== 8'd2) begin
            errors++;
            $display("FAIL err_two: err=%0b cnt=%0d expected 1 2", err_sel, err_count);
        end
        tick();
        err_clr = 1'b1; mode = 2'd1; sel_a = 5'd0; req_valid = 1'b1; tick();
        req_valid = 1'b0;
        checks++;
        if (err_sel !== 1'b1 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL err_clr_with_event: err=%0b cnt=%0d expected 1 1", err_sel, err_count);
        end
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_sel !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL err_clr_alone: err=%0b cnt=%0d expected 0 0", err_sel, err_count);
        end
    endtask

    task automatic test_saturation();
        bus_ready = 1'b1; mode = 2'd2; sel_b = 5'd16; req_valid = 1'b1;
        for (int i = 0; i < 254; i++) tick();
        checks++;
        if (err_count !== 8'd254) begin
            errors++;
            $display("FAIL sat_254: cnt=%0d expected 254", err_count);
        end
        for (int i = 0; i < 46; i++) tick();
        req_valid = 1'b0;
        checks++;
        if (err_count !== 8'd255 || err_sel !== 1'b1) begin
            errors++;
            $display("FAIL sat_255: cnt=%0d err=%0b expected 255 1", err_count, err_sel);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus_ready = 1'b0; mode = 2'd1; req_valid = 1'b1;
        sel_a = 5'd1; tick();
        sel_a = 5'd2; tick();
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || bus_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_full: ready=%0b valid=%0b expected 0 1", req_ready, bus_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_valid !== 1'b0 || err_count !== 8'd0 || err_sel !== 1'b0 || bus_out !== '0) begin
            errors++;
            $display("FAIL mid_async_reset: valid=%0b cnt=%0d err=%0b out=%h expected 0 0 0 0000",
                     bus_valid, err_count, err_sel, bus_out);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1 || bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: ready=%0b valid=%0b expected 1 0", req_ready, bus_valid);
        end
        bus_ready = 1'b1; tick();
        check_out("mid_stays_empty", 1'b0, '0, '0);
        set_src(15, 16'hBEEF);
        sel_a = 5'd15; req_valid = 1'b1; tick();
        req_valid = 1'b0;
        check_out("mid_totr_after", 1'b1, 16'hBEEF, 5'd15);
        tick();
    endtask

    initial begin
        test_reset();
        test_reg_select();
        test_imm_select();
        test_back_to_back();
        test_errors();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
